// File: rtl/cone_pkg.sv
// Shared constants and bitwise cone functions for the cone_pipe datapath.
// Latency: none (combinational helpers only).
// Backpressure: not applicable.
package cone_pkg;

  // Width of the optional output-handshake counter.
  localparam int CONE_CNT_W = 16;

  // Widest lane the helper functions cover. Callers widen their WIDTH-bit
  // operands to this size and truncate the result back. The functions are
  // purely bitwise, so the unused upper bits never influence the lower ones.
  localparam int CONE_MAX_W = 1024;

  typedef logic [CONE_MAX_W-1:0] cone_vec_t;

  // Second product term of the cone: ~(~a4&a0 | a2&~(a1&a3)), with p8 = a1&a3.
  function automatic cone_vec_t cone_p9(input cone_vec_t a0,
                                        input cone_vec_t a2,
                                        input cone_vec_t a4,
                                        input cone_vec_t p8);
    return ~((~a4 & a0) | (a2 & ~p8));
  endfunction

  // Final OAI: y = ~((p8 | p9) & p0).
  function automatic cone_vec_t cone_y(input cone_vec_t p8,
                                       input cone_vec_t p9,
                                       input cone_vec_t p0);
    return ~((p8 | p9) & p0);
  endfunction

endpackage

// File: rtl/cone_pipe_stage.sv
// One elastic pipeline slot: valid flag plus data register of width W.
// Latency: 1 cycle from a load to dout/valid.
// Backpressure: ready = ~valid | down_ready, purely combinational, so bubbles collapse.
module cone_stage
  import cone_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  input  logic         down_ready,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic         ready,
  output logic [W-1:0] dout
);

  // An empty slot can always load; a full one only if its contents move on.
  assign ready = ~valid | down_ready;

  // The valid flag follows the predecessor whenever this slot may load, so a
  // bubble upstream becomes a bubble here instead of stalling the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= up_valid;
    end
  end

  // Data is captured only for real items; bubbles leave the register alone,
  // which also keeps dout stable while the slot is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (ready && up_valid) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/cone_pipe.sv
// Vectorised five-input OAI cone, elastic-pipelined over DEPTH stages (optional CONE_STATS_EN adds xfer_cnt).
// Latency: DEPTH-1 cycles from input handshake to out_valid; one transfer per cycle when unstalled.
// Backpressure: valid/ready chain; a stalled consumer fills all DEPTH slots before in_ready drops.
module cone_pipe
  import cone_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] a4,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready
`ifdef CONE_STATS_EN
  ,
  output logic [CONE_CNT_W-1:0] xfer_cnt
`endif
);

  // Stage 0 packs {p8, p9, p0}; later stages carry only the WIDTH-bit result.
  localparam int S0_W = 3 * WIDTH;

  logic [DEPTH-1:0] vld;
  logic [DEPTH:0]   rdy;

  logic [WIDTH-1:0] p8_in;
  logic [WIDTH-1:0] p9_in;
  logic [S0_W-1:0]  s0_din;
  logic [S0_W-1:0]  s0_dout;
  logic [WIDTH-1:0] s0_p8;
  logic [WIDTH-1:0] s0_p9;
  logic [WIDTH-1:0] s0_p0;

  // yin[i] feeds stage i, ydat[i] is what stage i holds.
  logic [WIDTH-1:0] yin  [1:DEPTH-1];
  logic [WIDTH-1:0] ydat [1:DEPTH-1];

  // First half of the cone, evaluated on the raw operands ahead of stage 0.
  always_comb begin
    p8_in = a1 & a3;
    p9_in = WIDTH'(cone_p9(cone_vec_t'(a0), cone_vec_t'(a2),
                           cone_vec_t'(a4), cone_vec_t'(p8_in)));
  end

  assign s0_din = {p8_in, p9_in, a0};
  assign s0_p8  = s0_dout[S0_W-1 -: WIDTH];
  assign s0_p9  = s0_dout[2*WIDTH-1 -: WIDTH];
  assign s0_p0  = s0_dout[WIDTH-1:0];

  // The consumer closes the ready chain.
  assign rdy[DEPTH] = out_ready;

  cone_stage #(
    .W(S0_W)
  ) u_stage0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (in_valid),
    .down_ready (rdy[1]),
    .din        (s0_din),
    .valid      (vld[0]),
    .ready      (rdy[0]),
    .dout       (s0_dout)
  );

  for (genvar i = 1; i < DEPTH; i++) begin : g_stage
    if (i == 1) begin : g_fn
      // Second half of the cone sits between stage 0 and stage 1.
      assign yin[i] = WIDTH'(cone_y(cone_vec_t'(s0_p8), cone_vec_t'(s0_p9),
                                    cone_vec_t'(s0_p0)));
    end else begin : g_carry
      // Deeper stages only retime the finished result.
      assign yin[i] = ydat[i-1];
    end

    cone_stage #(
      .W(WIDTH)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (vld[i-1]),
      .down_ready (rdy[i+1]),
      .din        (yin[i]),
      .valid      (vld[i]),
      .ready      (rdy[i]),
      .dout       (ydat[i])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[DEPTH-1];
  assign y         = ydat[DEPTH-1];

`ifdef CONE_STATS_EN
  // Count completed output handshakes; the counter wraps at its full width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + CONE_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cone_pipe.sv
// Self-checking bench for cone_pipe: a narrow DEPTH=2 instance and a wide DEPTH=4 instance.
// Latency: n/a (testbench).
// Backpressure: out_ready driven by directed sequences and by random stimulus.
module tb_cone_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Narrow instance: WIDTH=4, DEPTH=2.
  logic [3:0] n_a0, n_a1, n_a2, n_a3, n_a4, n_y;
  logic       n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  // Wide instance: WIDTH=8, DEPTH=4.
  logic [7:0] w_a0, w_a1, w_a2, w_a3, w_a4, w_y;
  logic       w_in_valid, w_in_ready, w_out_valid, w_out_ready;
`ifdef CONE_STATS_EN
  logic [15:0] n_cnt, w_cnt;
`endif

  cone_pipe #(.WIDTH(4), .DEPTH(2)) dut_n (
    .clk(clk), .rst_n(rst_n),
    .a0(n_a0), .a1(n_a1), .a2(n_a2), .a3(n_a3), .a4(n_a4),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .y(n_y), .out_valid(n_out_valid), .out_ready(n_out_ready)
`ifdef CONE_STATS_EN
    , .xfer_cnt(n_cnt)
`endif
  );

  cone_pipe #(.WIDTH(8), .DEPTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .a0(w_a0), .a1(w_a1), .a2(w_a2), .a3(w_a3), .a4(w_a4),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .y(w_y), .out_valid(w_out_valid), .out_ready(w_out_ready)
`ifdef CONE_STATS_EN
    , .xfer_cnt(w_cnt)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference cone written straight from the function definition.
  function automatic logic [7:0] ref_y(input logic [7:0] a0, input logic [7:0] a1,
                                       input logic [7:0] a2, input logic [7:0] a3,
                                       input logic [7:0] a4);
    logic [7:0] n9;
    n9 = ~((~a4 & a0) | (a2 & ~(a1 & a3)));
    return ~(((a1 & a3) | n9) & a0);
  endfunction

  // Directed vectors for the narrow instance with hand-derived results.
  typedef struct {
    logic [3:0] a0, a1, a2, a3, a4;
    logic [3:0] y;
  } vec_t;
  vec_t tab [7];

  // Scoreboards: the driver sets *_exp_cur along with the operands; the
  // monitor pushes it when the input handshake actually happens.
  logic [3:0] n_exp_cur;
  logic [7:0] w_exp_cur;
  logic [3:0] qn [$];
  logic [7:0] qw [$];
  int n_hs = 0;
  int w_hs = 0;
  logic       n_hold = 1'b0, w_hold = 1'b0;
  logic [3:0] n_held_y, n_pop;
  logic [7:0] w_held_y, w_pop;

  // Narrow monitor: sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (n_hold) begin
        check_bit("n_stall_valid", n_out_valid, 1'b1);
        check_val("n_stall_y", 16'(n_y), 16'(n_held_y));
      end
      if (n_in_valid && n_in_ready) qn.push_back(n_exp_cur);
      if (n_out_valid && n_out_ready) begin
        if (qn.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL n_out_extra: y=%0h with empty scoreboard at %0t", n_y, $time);
        end else begin
          n_pop = qn.pop_front();
          check_val("n_out_y", 16'(n_y), 16'(n_pop));
        end
        n_hs++;
      end
      n_hold   = n_out_valid && !n_out_ready;
      n_held_y = n_y;
    end
  end

  // Wide monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (w_hold) begin
        check_bit("w_stall_valid", w_out_valid, 1'b1);
        check_val("w_stall_y", 16'(w_y), 16'(w_held_y));
      end
      if (w_in_valid && w_in_ready) qw.push_back(w_exp_cur);
      if (w_out_valid && w_out_ready) begin
        if (qw.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL w_out_extra: y=%0h with empty scoreboard at %0t", w_y, $time);
        end else begin
          w_pop = qw.pop_front();
          check_val("w_out_y", 16'(w_y), 16'(w_pop));
        end
        w_hs++;
      end
      w_hold   = w_out_valid && !w_out_ready;
      w_held_y = w_y;
    end
  end

  task automatic n_set(input int i);
    n_a0 = tab[i].a0; n_a1 = tab[i].a1; n_a2 = tab[i].a2;
    n_a3 = tab[i].a3; n_a4 = tab[i].a4;
    n_exp_cur  = tab[i].y;
    n_in_valid = 1'b1;
  endtask

  task automatic w_set_random();
    w_a0 = 8'($urandom); w_a1 = 8'($urandom); w_a2 = 8'($urandom);
    w_a3 = 8'($urandom); w_a4 = 8'($urandom);
    w_exp_cur  = ref_y(w_a0, w_a1, w_a2, w_a3, w_a4);
    w_in_valid = 1'b1;
  endtask

  // Back-to-back table beats into an empty narrow pipe with out_ready high.
  task automatic n_burst(input int first, input int last);
    n_out_ready = 1'b1;
    for (int j = first; j <= last; j++) begin
      n_set(j);
      @(posedge clk); #1;
      if (j == first) check_bit("n_latency_early", n_out_valid, 1'b0);
      else            check_bit("n_no_bubble", n_out_valid, 1'b1);
    end
    n_in_valid = 1'b0;
    @(posedge clk); #1;
    check_bit("n_last_out", n_out_valid, 1'b1);
    @(posedge clk); #1;
    check_bit("n_empty_after", n_out_valid, 1'b0);
  endtask

  task automatic n_drain();
    int k = 0;
    n_in_valid  = 1'b0;
    n_out_ready = 1'b1;
    while ((qn.size() != 0 || n_out_valid) && k < 40) begin
      @(posedge clk); #1; k++;
    end
    check_bit("n_drained", (qn.size() == 0) && !n_out_valid, 1'b1);
  endtask

  task automatic w_drain();
    int k = 0;
    w_in_valid  = 1'b0;
    w_out_ready = 1'b1;
    while ((qw.size() != 0 || w_out_valid) && k < 80) begin
      @(posedge clk); #1; k++;
    end
    check_bit("w_drained", (qw.size() == 0) && !w_out_valid, 1'b1);
  endtask

  initial begin
    int hs0;
    tab[0] = '{4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0};
    tab[1] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
    tab[2] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'hF};
    tab[3] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
    tab[4] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0};
    tab[5] = '{4'hA, 4'hC, 4'h5, 4'h6, 4'h3, 4'hD};
    tab[6] = '{4'h5, 4'h3, 4'h9, 4'h6, 4'hC, 4'hB};

    rst_n = 1'b0;
    n_a0 = '0; n_a1 = '0; n_a2 = '0; n_a3 = '0; n_a4 = '0;
    w_a0 = '0; w_a1 = '0; w_a2 = '0; w_a3 = '0; w_a4 = '0;
    n_in_valid = 1'b0; n_out_ready = 1'b1; n_exp_cur = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_exp_cur = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    check_bit("n_rst_out_valid", n_out_valid, 1'b0);
    check_bit("n_rst_in_ready", n_in_ready, 1'b1);
    check_val("n_rst_y", 16'(n_y), 16'h0);
    check_bit("w_rst_out_valid", w_out_valid, 1'b0);
    check_bit("w_rst_in_ready", w_in_ready, 1'b1);
    check_val("w_rst_y", 16'(w_y), 16'h0);
`ifdef CONE_STATS_EN
    check_val("n_rst_xfer_cnt", n_cnt, 16'h0);
    check_val("w_rst_xfer_cnt", w_cnt, 16'h0);
`endif
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single beat latency, then back-to-back streams from the table.
    n_burst(0, 0);
    n_burst(1, 4);
    n_burst(5, 6);

    // Consumer stall: two beats fill the pipe, the third waits.
    hs0 = n_hs;
    n_out_ready = 1'b0;
    n_set(0); @(posedge clk); #1;
    check_bit("n_accept2_ready", n_in_ready, 1'b1);
    n_set(5); @(posedge clk); #1;
    check_bit("n_full_in_ready", n_in_ready, 1'b0);
    n_set(6);
    repeat (3) begin
      @(posedge clk); #1;
      check_bit("n_stall_in_ready", n_in_ready, 1'b0);
    end
    n_out_ready = 1'b1;
    #1 check_bit("n_pushpop_in_ready", n_in_ready, 1'b1);
    @(posedge clk); #1;
    check_bit("n_pushpop_full", n_out_valid, 1'b1);
    n_drain();
    check_val("n_stall_count", 16'(n_hs - hs0), 16'd3);

    // Reset mid-stream with two items in flight.
    n_out_ready = 1'b0;
    n_set(0); @(posedge clk); #1;
    n_set(5); @(posedge clk); #1;
    n_in_valid = 1'b0;
    check_bit("n_inflight_valid", n_out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_bit("n_async_drop_valid", n_out_valid, 1'b0);
    check_bit("n_async_in_ready", n_in_ready, 1'b1);
    check_val("n_async_y", 16'(n_y), 16'h0);
`ifdef CONE_STATS_EN
    check_val("n_async_xfer_cnt", n_cnt, 16'h0);
    check_val("w_async_xfer_cnt", w_cnt, 16'h0);
`endif
    qn.delete(); qw.delete();
    n_hs = 0; w_hs = 0;
    n_hold = 1'b0; w_hold = 1'b0;
    #1 rst_n = 1'b1;
    n_out_ready = 1'b1;
    @(posedge clk); #1;
    n_burst(6, 6);
    n_drain();
    check_val("n_post_reset_count", 16'(n_hs), 16'd1);

    // Wide instance: DEPTH-1 cycle latency.
    w_set_random();
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_bit("w_latency_early", w_out_valid, 1'b0);
      @(posedge clk); #1;
    end
    check_bit("w_latency_arrive", w_out_valid, 1'b1);
    w_drain();

    // Wide instance: four items fill the pipe before in_ready drops.
    w_out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check_bit("w_fill_in_ready", w_in_ready, 1'b1);
      w_set_random();
      @(posedge clk); #1;
    end
    check_bit("w_full_in_ready", w_in_ready, 1'b0);
    w_set_random();
    repeat (2) begin
      @(posedge clk); #1;
      check_bit("w_stall_in_ready", w_in_ready, 1'b0);
    end
    w_drain();

    // Random traffic on the wide instance.
    for (int c = 0; c < 10000; c++) begin
      w_set_random();
      w_in_valid  = ($urandom_range(0, 3) != 0);
      w_out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    w_drain();

`ifdef CONE_STATS_EN
    check_val("n_xfer_cnt", n_cnt, 16'(n_hs));
    check_val("w_xfer_cnt", w_cnt, 16'(w_hs));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #1000000;
    tests_failed++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

endmodule
